// File: rtl/rom2ram.sv
// rom2ram: copies BYTES bytes from a boot-image source into SRAM at
// power-up. While the copy runs, `active` holds the CPU in reset. Each byte
// is handled without overlap: it is fetched from the source, then its
// address and data are set up, then it is strobed into SRAM, then the bus
// is left idle for a recovery gap.
//
// Ports
//   clk28               in   1   system clock (single domain)
//   rst                 in   1   asynchronous, active-high reset
//   restart             in   1   one-cycle request to repeat the copy (DONE only)
//   src_addr            out  17  byte address into the source image
//   src_data            in   8   source byte, valid SRC_LATENCY cycles after src_addr
//   rom2ram_ram_address out  17  SRAM byte address
//   rom2ram_ram_wren    out  1   SRAM write strobe (registered)
//   rom2ram_dataout     out  8   SRAM write data
//   active              out  1   copy in progress
//   done                out  1   copy complete
//
// state | meaning
// FETCH | src_addr = index, wait SRC_LATENCY cycles, capture src_data on the last one
// SETUP | address/data presented to SRAM, strobe low (1 cycle)
// WRITE | strobe high for WR_WIDTH cycles
// HOLD  | strobe low for GAP recovery cycles (skipped when GAP = 0)
// DONE  | copy finished; restart re-enters FETCH at index 0

module rom2ram #(
   parameter int unsigned BYTES       = 114688,
   parameter int unsigned SRC_LATENCY = 2,
   parameter int unsigned WR_WIDTH    = 2,
   parameter int unsigned GAP         = 1
) (
   input  logic        clk28,
   input  logic        rst,
   input  logic        restart,
   output logic [16:0] src_addr,
   input  logic [7:0]  src_data,
   output logic [16:0] rom2ram_ram_address,
   output logic        rom2ram_ram_wren,
   output logic [7:0]  rom2ram_dataout,
   output logic        active,
   output logic        done
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_SETUP,
      S_WRITE,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [16:0] LAST_IDX = 17'(BYTES - 1);
   localparam logic [2:0]  LAT_TC   = 3'(SRC_LATENCY - 1);
   localparam logic [2:0]  WR_TC    = 3'(WR_WIDTH - 1);
   // GAP_TC is only compared while in HOLD, which is unreachable when GAP = 0.
   localparam logic [2:0]  GAP_TC   = (GAP == 0) ? 3'd0 : 3'(GAP - 1);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_next;
   logic [16:0] r_index;
   logic [16:0] w_index_next;
   logic        w_capture;
   logic        w_byte_end;

   logic [16:0] r_ram_addr;
   logic [7:0]  r_dataout;
   logic        r_wren;
   logic        r_active;
   logic        r_done;

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_cnt   <= 3'd0;
         r_index <= 17'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_index <= w_index_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt + 3'd1;
      w_index_next = r_index;
      w_capture    = 1'b0;
      w_byte_end   = 1'b0;

      case (r_state)
         S_FETCH: begin
            if (r_cnt == LAT_TC) begin
               w_next     = S_SETUP;
               w_cnt_next = 3'd0;
               w_capture  = 1'b1;
            end
         end
         S_SETUP: begin
            w_next     = S_WRITE;
            w_cnt_next = 3'd0;
         end
         S_WRITE: begin
            if (r_cnt == WR_TC) begin
               w_cnt_next = 3'd0;
               if (GAP == 0) begin
                  w_byte_end = 1'b1;
               end else begin
                  w_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (r_cnt == GAP_TC) begin
               w_cnt_next = 3'd0;
               w_byte_end = 1'b1;
            end
         end
         S_DONE: begin
            w_cnt_next = 3'd0;
            if (restart) begin
               w_next       = S_FETCH;
               w_index_next = 17'd0;
            end
         end
         default: begin
            w_next       = S_FETCH;
            w_cnt_next   = 3'd0;
            w_index_next = 17'd0;
         end
      endcase

      // Compare against the last index before incrementing so the 17-bit
      // index never has to hold BYTES itself.
      if (w_byte_end) begin
         if (r_index == LAST_IDX) begin
            w_next = S_DONE;
         end else begin
            w_next       = S_FETCH;
            w_index_next = r_index + 17'd1;
         end
      end
   end

   // Outputs are flops decoded from the next state, so they line up with the
   // state register and cannot glitch.
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         r_ram_addr <= 17'd0;
         r_dataout  <= 8'd0;
         r_wren     <= 1'b0;
         r_active   <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_wren   <= (w_next == S_WRITE);
         r_active <= (w_next != S_DONE);
         r_done   <= (w_next == S_DONE);
         if (w_capture) begin
            r_ram_addr <= r_index;
            r_dataout  <= src_data;
         end
      end
   end

   assign src_addr            = r_index;
   assign rom2ram_ram_address = r_ram_addr;
   assign rom2ram_dataout     = r_dataout;
   assign rom2ram_ram_wren    = r_wren;
   assign active              = r_active;
   assign done                = r_done;

endmodule

// File: tb/tb_rom2ram.sv
// Directed bench for rom2ram. Four instances cover the parameter sets of
// interest; only the instance under test is out of reset at any time.
// Cycle 0 is the cycle in which rst is released (released on a falling edge).

module tb_rom2ram;

   logic clk28;
   logic restart;
   logic rst_4, rst_2, rst_1, rst_big;
   int   sel;

   logic [16:0] sa_4, ra_4, sa_2, ra_2, sa_1, ra_1, sa_big, ra_big;
   logic [7:0]  sd_4, do_4, sd_2, do_2, sd_1, do_1, sd_big, do_big;
   logic        we_4, ac_4, dn_4, we_2, ac_2, dn_2, we_1, ac_1, dn_1;
   logic        we_big, ac_big, dn_big;

   assign sd_4   = 8'hA0 + sa_4[7:0];
   assign sd_2   = 8'hA0 + sa_2[7:0];
   assign sd_1   = 8'hA0 + sa_1[7:0];
   assign sd_big = 8'hA0 + sa_big[7:0];

   rom2ram #(.BYTES(4)) u4 (
      .clk28(clk28), .rst(rst_4), .restart(restart), .src_addr(sa_4), .src_data(sd_4),
      .rom2ram_ram_address(ra_4), .rom2ram_ram_wren(we_4), .rom2ram_dataout(do_4),
      .active(ac_4), .done(dn_4));

   rom2ram #(.BYTES(2), .SRC_LATENCY(1), .WR_WIDTH(1), .GAP(0)) u2 (
      .clk28(clk28), .rst(rst_2), .restart(restart), .src_addr(sa_2), .src_data(sd_2),
      .rom2ram_ram_address(ra_2), .rom2ram_ram_wren(we_2), .rom2ram_dataout(do_2),
      .active(ac_2), .done(dn_2));

   rom2ram #(.BYTES(1)) u1 (
      .clk28(clk28), .rst(rst_1), .restart(restart), .src_addr(sa_1), .src_data(sd_1),
      .rom2ram_ram_address(ra_1), .rom2ram_ram_wren(we_1), .rom2ram_dataout(do_1),
      .active(ac_1), .done(dn_1));

   rom2ram #(.BYTES(131072)) ubig (
      .clk28(clk28), .rst(rst_big), .restart(restart), .src_addr(sa_big), .src_data(sd_big),
      .rom2ram_ram_address(ra_big), .rom2ram_ram_wren(we_big), .rom2ram_dataout(do_big),
      .active(ac_big), .done(dn_big));

   initial begin
      clk28 = 1'b0;
      forever #5 clk28 = ~clk28;
   end

   logic [16:0] m_sa, m_ra;
   logic [7:0]  m_do;
   logic        m_we, m_ac, m_dn;

   always_comb begin
      m_sa = sa_4; m_ra = ra_4; m_do = do_4; m_we = we_4; m_ac = ac_4; m_dn = dn_4;
      case (sel)
         1: begin m_sa = sa_2;   m_ra = ra_2;   m_do = do_2;   m_we = we_2;   m_ac = ac_2;   m_dn = dn_2;   end
         2: begin m_sa = sa_1;   m_ra = ra_1;   m_do = do_1;   m_we = we_1;   m_ac = ac_1;   m_dn = dn_1;   end
         3: begin m_sa = sa_big; m_ra = ra_big; m_do = do_big; m_we = we_big; m_ac = ac_big; m_dn = dn_big; end
         default: ;
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;

   int          wr_cyc [32];
   logic [16:0] wr_addr[32];
   logic [7:0]  wr_data[32];
   int          wr_w   [32];
   int          n_wr, n_done, act_fall, act_rise, n_both, n_chg, n_hold;
   int          done_cyc[2];

   // Records write pulses and done/active edges of the selected instance.
   task automatic observe(input int ncyc, input int rs_a, input int rs_b);
      logic [16:0] p_addr;
      logic [7:0]  p_do;
      logic        p_we, p_dn, p_ac;
      n_wr = 0; n_done = 0; act_fall = -1; act_rise = -1;
      n_both = 0; n_chg = 0; n_hold = 0;
      done_cyc[0] = -1; done_cyc[1] = -1;
      for (int i = 0; i < 32; i++) wr_w[i] = 0;
      p_we = 1'b0; p_dn = 1'b0; p_ac = 1'b1; p_addr = 17'd0; p_do = 8'd0;
      for (int c = 0; c < ncyc; c++) begin
         #1;
         if (m_ac && m_dn) n_both++;
         if (m_we && (m_ra != p_addr)) n_chg++;
         if (m_we && p_we && (m_do != p_do)) n_hold++;
         if (m_we && !p_we && n_wr < 32) begin
            wr_cyc[n_wr] = c; wr_addr[n_wr] = m_ra; wr_data[n_wr] = m_do;
            n_wr++;
         end
         if (m_we && n_wr > 0) wr_w[n_wr-1]++;
         if (m_dn && !p_dn) begin
            if (n_done < 2) done_cyc[n_done] = c;
            n_done++;
         end
         if (!m_ac && p_ac && act_fall < 0) act_fall = c;
         if (m_ac && !p_ac && act_rise < 0) act_rise = c;
         restart = (c == rs_a) || (c == rs_b);
         p_we = m_we; p_dn = m_dn; p_ac = m_ac; p_addr = m_ra; p_do = m_do;
         @(negedge clk28);
      end
      restart = 1'b0;
   endtask

   task automatic test_reset();
      sel = 0;
      rst_4 = 1'b1;
      repeat (3) @(negedge clk28);
      #1;
      n_checks++; if (m_sa !== 17'd0) begin n_fail++; $display("FAIL reset_src_addr: got %h want 0", m_sa); end
      n_checks++; if (m_ra !== 17'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 0", m_ra); end
      n_checks++; if (m_do !== 8'd0)  begin n_fail++; $display("FAIL reset_dataout: got %h want 0", m_do); end
      n_checks++; if (m_we !== 1'b0)  begin n_fail++; $display("FAIL reset_wren: got %b want 0", m_we); end
      n_checks++; if (m_ac !== 1'b1)  begin n_fail++; $display("FAIL reset_active: got %b want 1", m_ac); end
      n_checks++; if (m_dn !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", m_dn); end
   endtask

   task automatic test_normal_copy();
      sel = 0;
      rst_4 = 1'b1;
      @(negedge clk28);
      rst_4 = 1'b0;
      observe(30, -1, -1);
      n_checks++; if (n_wr !== 4) begin n_fail++; $display("FAIL normal_nwrites: got %0d want 4", n_wr); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (wr_addr[i] !== 17'(i)) begin n_fail++; $display("FAIL normal_addr[%0d]: got %h want %h", i, wr_addr[i], i); end
         n_checks++; if (wr_data[i] !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL normal_data[%0d]: got %h want %h", i, wr_data[i], 8'hA0 + i); end
         n_checks++; if (wr_cyc[i] !== 3 + 6*i) begin n_fail++; $display("FAIL normal_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], 3 + 6*i); end
         n_checks++; if (wr_w[i] !== 2) begin n_fail++; $display("FAIL normal_wren_width[%0d]: got %0d want 2", i, wr_w[i]); end
      end
      n_checks++; if (done_cyc[0] !== 24) begin n_fail++; $display("FAIL normal_done_cycle: got %0d want 24", done_cyc[0]); end
      n_checks++; if (act_fall !== 24) begin n_fail++; $display("FAIL normal_active_fall: got %0d want 24", act_fall); end
      n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL normal_active_and_done: got %0d cycles want 0", n_both); end
      n_checks++; if (n_hold !== 0) begin n_fail++; $display("FAIL normal_data_hold: got %0d changes want 0", n_hold); end
      rst_4 = 1'b1;
   endtask

   task automatic test_timing();
      sel = 1;
      rst_2 = 1'b1;
      @(negedge clk28);
      rst_2 = 1'b0;
      observe(12, -1, -1);
      n_checks++; if (n_wr !== 2) begin n_fail++; $display("FAIL timing_nwrites: got %0d want 2", n_wr); end
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (wr_cyc[i] !== 2 + 3*i) begin n_fail++; $display("FAIL timing_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], 2 + 3*i); end
         n_checks++; if (wr_addr[i] !== 17'(i)) begin n_fail++; $display("FAIL timing_addr[%0d]: got %h want %h", i, wr_addr[i], i); end
         n_checks++; if (wr_data[i] !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL timing_data[%0d]: got %h want %h", i, wr_data[i], 8'hA0 + i); end
         n_checks++; if (wr_w[i] !== 1) begin n_fail++; $display("FAIL timing_wren_width[%0d]: got %0d want 1", i, wr_w[i]); end
      end
      n_checks++; if (done_cyc[0] !== 6) begin n_fail++; $display("FAIL timing_done_cycle: got %0d want 6", done_cyc[0]); end
      n_checks++; if (n_chg !== 0) begin n_fail++; $display("FAIL timing_wren_on_addr_change: got %0d want 0", n_chg); end
      rst_2 = 1'b1;
   endtask

   task automatic test_restart();
      sel = 0;
      rst_4 = 1'b1;
      @(negedge clk28);
      rst_4 = 1'b0;
      observe(62, 10, 30);
      n_checks++; if (n_wr !== 8) begin n_fail++; $display("FAIL restart_nwrites: got %0d want 8", n_wr); end
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (wr_addr[i] !== 17'(i % 4)) begin n_fail++; $display("FAIL restart_addr[%0d]: got %h want %h", i, wr_addr[i], i % 4); end
         n_checks++; if (wr_data[i] !== 8'(8'hA0 + (i % 4))) begin n_fail++; $display("FAIL restart_data[%0d]: got %h want %h", i, wr_data[i], 8'hA0 + (i % 4)); end
         n_checks++; if (wr_cyc[i] !== ((i < 4) ? 3 + 6*i : 34 + 6*(i-4))) begin n_fail++; $display("FAIL restart_wr_cycle[%0d]: got %0d", i, wr_cyc[i]); end
      end
      n_checks++; if (done_cyc[0] !== 24) begin n_fail++; $display("FAIL restart_first_done: got %0d want 24", done_cyc[0]); end
      n_checks++; if (act_rise !== 31) begin n_fail++; $display("FAIL restart_active_rise: got %0d want 31", act_rise); end
      n_checks++; if (done_cyc[1] !== 55) begin n_fail++; $display("FAIL restart_second_done: got %0d want 55", done_cyc[1]); end
      n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL restart_active_and_done: got %0d want 0", n_both); end
      rst_4 = 1'b1;
   endtask

   task automatic test_reset_midwrite();
      sel = 0;
      rst_4 = 1'b1;
      @(negedge clk28);
      rst_4 = 1'b0;
      repeat (15) @(posedge clk28);
      #2;
      n_checks++; if (m_we !== 1'b1) begin n_fail++; $display("FAIL midwrite_pre_wren: got %b want 1", m_we); end
      n_checks++; if (m_ra !== 17'd2) begin n_fail++; $display("FAIL midwrite_pre_addr: got %h want 2", m_ra); end
      rst_4 = 1'b1;
      #1;
      n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL midwrite_wren_drop: got %b want 0", m_we); end
      n_checks++; if (m_sa !== 17'd0 || m_ra !== 17'd0 || m_do !== 8'd0) begin
         n_fail++; $display("FAIL midwrite_reset_values: src %h addr %h data %h want 0/0/0", m_sa, m_ra, m_do);
      end
      n_checks++; if (m_ac !== 1'b1 || m_dn !== 1'b0) begin n_fail++; $display("FAIL midwrite_active_done: got %b/%b want 1/0", m_ac, m_dn); end
      repeat (2) @(negedge clk28);
      rst_4 = 1'b0;
      observe(30, -1, -1);
      n_checks++; if (n_wr !== 4) begin n_fail++; $display("FAIL midwrite_nwrites: got %0d want 4", n_wr); end
      n_checks++; if (wr_addr[0] !== 17'd0 || wr_data[0] !== 8'hA0) begin n_fail++; $display("FAIL midwrite_first_write: got %h/%h want 0/a0", wr_addr[0], wr_data[0]); end
      n_checks++; if (wr_addr[3] !== 17'd3) begin n_fail++; $display("FAIL midwrite_last_addr: got %h want 3", wr_addr[3]); end
      n_checks++; if (done_cyc[0] !== 24) begin n_fail++; $display("FAIL midwrite_done_cycle: got %0d want 24", done_cyc[0]); end
      rst_4 = 1'b1;
   endtask

   task automatic test_boundary_one();
      sel = 2;
      rst_1 = 1'b1;
      @(negedge clk28);
      rst_1 = 1'b0;
      observe(14, -1, -1);
      n_checks++; if (n_wr !== 1) begin n_fail++; $display("FAIL one_nwrites: got %0d want 1", n_wr); end
      n_checks++; if (wr_addr[0] !== 17'd0 || wr_data[0] !== 8'hA0) begin n_fail++; $display("FAIL one_write: got %h/%h want 0/a0", wr_addr[0], wr_data[0]); end
      n_checks++; if (done_cyc[0] !== 6) begin n_fail++; $display("FAIL one_done_cycle: got %0d want 6", done_cyc[0]); end
      n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL one_active_and_done: got %0d want 0", n_both); end
      rst_1 = 1'b1;
   endtask

   task automatic test_boundary_big();
      sel = 3;
      rst_big = 1'b1;
      @(negedge clk28);
      rst_big = 1'b0;
      observe(62, 20, -1);
      n_checks++; if (n_wr !== 10) begin n_fail++; $display("FAIL big_nwrites: got %0d want 10", n_wr); end
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (wr_addr[i] !== 17'(i) || wr_data[i] !== 8'(8'hA0 + i)) begin
            n_fail++; $display("FAIL big_write[%0d]: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], i, 8'hA0 + i);
         end
      end
      n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL big_early_done: got %0d rises want 0", n_done); end
      n_checks++; if (m_ac !== 1'b1) begin n_fail++; $display("FAIL big_active: got %b want 1", m_ac); end
      n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL big_active_and_done: got %0d want 0", n_both); end
      rst_big = 1'b1;
   endtask

   initial begin
      restart = 1'b0;
      sel     = 0;
      rst_4 = 1'b1; rst_2 = 1'b1; rst_1 = 1'b1; rst_big = 1'b1;
      repeat (2) @(negedge clk28);
      test_reset();
      test_normal_copy();
      test_timing();
      test_restart();
      test_reset_midwrite();
      test_boundary_one();
      test_boundary_big();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
